// File: rtl/softmax_out_serializer.sv
// -----------------------------------------------------------------------------
// softmax_out_serializer
//
// Output stage behind the 64-lane softmax approximation pipeline. Each
// 1024-bit probability vector (64 lanes x 16 bits) is captured together with
// its length mode into a two-entry buffer. The head vector is then streamed
// out as 16 beats of 4 lanes over a valid/ready handshake, with row
// boundaries marked according to the length mode. The pipeline enable is
// held low while both entries are occupied, so no vector is dropped while
// the consumer stalls.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_valid        probability vector present on i_prob_flat
//   i_prob_flat    64 lanes, lane k at [k*16 +: 16]
//   i_length_mode  0 = 16-mode, 1 = 32-mode, 2 and above = 64-mode
//   o_en           enable to the softmax pipeline (buffer has a free entry)
//   o_valid        beat available
//   i_ready        consumer accepts the beat
//   o_data         lanes 4b..4b+3 of the head vector, lane 4b+j at [j*16 +: 16]
//   o_beat         beat index b, 0..15
//   o_row          row index of the current beat within the vector
//   o_last         last beat of a row
//   o_rows_done    count of completed rows, wraps at 16 bits
// -----------------------------------------------------------------------------
module softmax_out_serializer (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   input  logic [1023:0] i_prob_flat,
   input  logic [3:0]    i_length_mode,
   output logic          o_en,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [63:0]   o_data,
   output logic [3:0]    o_beat,
   output logic [1:0]    o_row,
   output logic          o_last,
   output logic [15:0]   o_rows_done
);

   localparam int VEC_W  = 1024;
   localparam int BEAT_W = 64;

   // Stored length-mode codes
   localparam logic [1:0] MODE_16 = 2'd0;
   localparam logic [1:0] MODE_32 = 2'd1;
   localparam logic [1:0] MODE_64 = 2'd2;

   logic [VEC_W-1:0] r_data [2];
   logic [1:0]       r_mode [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [3:0]       r_beat;
   logic [15:0]      r_rows_done;

   logic             w_en;
   logic             w_valid;
   logic             w_push;
   logic             w_accept;
   logic             w_pop;
   logic [1:0]       w_mode_in;
   logic [1:0]       w_head_mode;
   logic [VEC_W-1:0] w_head;
   logic [1:0]       w_row;
   logic             w_last;

   // Handshake qualifiers; everything here is derived from registered state
   // plus the two handshake inputs, which only steer the next-state logic.
   assign w_en     = (r_count < 2'd2);
   assign w_valid  = (r_count != 2'd0);
   assign w_push   = i_valid && w_en;
   assign w_accept = w_valid && i_ready;
   assign w_pop    = w_accept && (r_beat == 4'd15);

   always_comb begin
      w_mode_in = MODE_64;
      if (i_length_mode == 4'd0)
         w_mode_in = MODE_16;
      else if (i_length_mode == 4'd1)
         w_mode_in = MODE_32;
   end

   assign w_head      = r_data[r_rd_ptr];
   assign w_head_mode = r_mode[r_rd_ptr];

   // Row framing of the current beat; forced to zero while nothing is valid.
   always_comb begin
      w_row  = 2'd0;
      w_last = 1'b0;
      if (w_valid) begin
         case (w_head_mode)
            MODE_16: begin
               w_row  = r_beat[3:2];
               w_last = &r_beat[1:0];
            end
            MODE_32: begin
               w_row  = {1'b0, r_beat[3]};
               w_last = &r_beat[2:0];
            end
            default: begin
               w_row  = 2'd0;
               w_last = &r_beat;
            end
         endcase
      end
   end

   // Buffer storage: only the entry under the write pointer is loaded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_mode[i] <= MODE_16;
         end
      end else if (w_push) begin
         r_data[r_wr_ptr] <= i_prob_flat;
         r_mode[r_wr_ptr] <= w_mode_in;
      end
   end

   // Pointers and occupancy. A push and pop in the same cycle (only possible
   // with one entry, since o_en is low when full) leave the count unchanged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push)
            r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Beat counter wraps 15 -> 0 exactly when the head is popped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_beat      <= 4'd0;
         r_rows_done <= 16'd0;
      end else if (w_accept) begin
         r_beat <= r_beat + 4'd1;
         if (w_last)
            r_rows_done <= r_rows_done + 16'd1;
      end
   end

   assign o_en        = w_en;
   assign o_valid     = w_valid;
   assign o_data      = w_valid ? w_head[{r_beat, 6'd0} +: BEAT_W] : '0;
   assign o_beat      = r_beat;
   assign o_row       = w_row;
   assign o_last      = w_last;
   assign o_rows_done = r_rows_done;

endmodule

// File: tb/tb_softmax_out_serializer.sv
module tb_softmax_out_serializer;

   logic          clk;
   logic          i_rst_n;
   logic          i_valid;
   logic [1023:0] i_prob_flat;
   logic [3:0]    i_length_mode;
   logic          o_en;
   logic          o_valid;
   logic          i_ready;
   logic [63:0]   o_data;
   logic [3:0]    o_beat;
   logic [1:0]    o_row;
   logic          o_last;
   logic [15:0]   o_rows_done;

   softmax_out_serializer dut (
      .i_clk         (clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .i_prob_flat   (i_prob_flat),
      .i_length_mode (i_length_mode),
      .o_en          (o_en),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_data        (o_data),
      .o_beat        (o_beat),
      .o_row         (o_row),
      .o_last        (o_last),
      .o_rows_done   (o_rows_done)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  beat;
      logic [1:0]  row;
      logic        last;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = pseudo-random
   logic [15:0] exp_rows;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [1023:0] mkvec(input int base);
      logic [1023:0] v;
      for (int k = 0; k < 64; k++) v[k*16 +: 16] = 16'(base + k);
      return v;
   endfunction

   function automatic logic [63:0] beat_data(input int base, input int b);
      logic [63:0] d;
      for (int j = 0; j < 4; j++) d[j*16 +: 16] = 16'(base + 4*b + j);
      return d;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic cyc();
      if (ready_mode == 2) i_ready = 1'($urandom_range(0, 1));
      else                 i_ready = (ready_mode == 1);
      @(posedge clk);
      #1;
   endtask

   // Present a vector until the DUT takes it, then queue its 16 expected beats.
   task automatic push_vec(input int base, input logic [3:0] mode);
      logic en_pre;
      logic accepted;
      int   n;
      exp_t e;
      i_prob_flat   = mkvec(base);
      i_length_mode = mode;
      i_valid       = 1'b1;
      accepted      = 1'b0;
      n             = 0;
      while (!accepted && n < 200) begin
         en_pre = o_en;
         cyc();
         n++;
         if (en_pre) accepted = 1'b1;
      end
      i_valid = 1'b0;
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL push_timeout actual=not_taken required=taken base=%0d", base);
      end else begin
         for (int b = 0; b < 16; b++) begin
            e.data = beat_data(base, b);
            e.beat = 4'(b);
            if (mode == 4'd0) begin
               e.row  = 2'(b / 4);
               e.last = ((b % 4) == 3);
            end else if (mode == 4'd1) begin
               e.row  = 2'(b / 8);
               e.last = ((b % 8) == 7);
            end else begin
               e.row  = 2'd0;
               e.last = (b == 15);
            end
            q.push_back(e);
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         cyc();
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d_left required=0", q.size());
      end
      cyc();
      cyc();
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      #1;
   endtask

   // Monitor: compares every presented beat against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!i_rst_n) begin
            q.delete();
            exp_rows = 16'd0;
         end else begin
            chk("rows_done", 64'(o_rows_done), 64'(exp_rows));
            if (o_valid) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual=beat%0d data=%h required=no_beat", o_beat, o_data);
               end else begin
                  e = q[0];
                  checks++;
                  if ({o_data, o_beat, o_row, o_last} !== e) begin
                     errors++;
                     $display("FAIL beat actual=%h/%0d/%0d/%0d required=%h/%0d/%0d/%0d",
                              o_data, o_beat, o_row, o_last, e.data, e.beat, e.row, e.last);
                  end
                  if (i_ready) begin
                     e = q.pop_front();
                     if (e.last) exp_rows = exp_rows + 16'd1;
                  end
               end
            end else begin
               chk("idle_outputs", {o_data[60:0], o_row, o_last}, 64'd0);
            end
         end
      end
   end

   initial begin
      i_rst_n       = 1'b0;
      i_valid       = 1'b0;
      i_prob_flat   = '0;
      i_length_mode = 4'd0;
      i_ready       = 1'b0;
      #12;
      chk("rst_en",    64'(o_en),    64'd1);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_data",  o_data,       64'd0);
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      #1;
      chk("post_rst_en",    64'(o_en),    64'd1);
      chk("post_rst_valid", 64'(o_valid), 64'd0);
      chk("post_rst_rows",  64'(o_rows_done), 64'd0);

      // Single 64-mode vector, lane k = k
      ready_mode = 1;
      push_vec(0, 4'd2);
      chk("first_beat_latency", 64'({o_valid, o_beat}), 64'h10);
      drain(100);
      chk("rows_after_64", 64'(o_rows_done), 64'd1);

      // 16-mode then 32-mode framing from a fresh count
      do_reset();
      push_vec(1000, 4'd0);
      push_vec(2000, 4'd1);
      drain(100);
      chk("rows_after_16_32", 64'(o_rows_done), 64'd6);

      // Backpressure fill: third vector must wait, not duplicate
      ready_mode = 0;
      push_vec(100, 4'd2);
      push_vec(200, 4'd1);
      chk("full_en", 64'(o_en), 64'd0);
      chk("full_head", 64'({o_valid, o_beat}), 64'h10);
      i_prob_flat   = mkvec(300);
      i_length_mode = 4'd0;
      i_valid       = 1'b1;
      repeat (3) begin
         cyc();
         chk("full_hold_en", 64'(o_en), 64'd0);
      end
      ready_mode = 1;
      push_vec(300, 4'd0);
      drain(200);

      // Pseudo-random consumer stalls
      ready_mode = 2;
      push_vec(400, 4'd9);
      push_vec(500, 4'd0);
      push_vec(600, 4'd1);
      drain(800);

      // Push on the same edge that the final beat of the head is accepted
      ready_mode = 1;
      push_vec(650, 4'd2);
      repeat (15) cyc();
      chk("pre_pop_beat", 64'(o_beat), 64'd15);
      push_vec(660, 4'd0);
      chk("simul_valid_beat", 64'({o_valid, o_beat}), 64'h10);
      chk("simul_en", 64'(o_en), 64'd1);
      chk("simul_data", o_data, beat_data(660, 0));
      drain(100);

      // Asynchronous reset in the middle of a two-entry buffer
      ready_mode = 0;
      push_vec(700, 4'd2);
      push_vec(800, 4'd0);
      ready_mode = 1;
      repeat (6) cyc();
      chk("pre_reset_beat", 64'(o_beat), 64'd6);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(o_valid),     64'd0);
      chk("async_rows",  64'(o_rows_done), 64'd0);
      chk("async_en",    64'(o_en),        64'd1);
      chk("async_data",  o_data,           64'd0);
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      repeat (20) cyc();
      chk("after_reset_en",    64'(o_en),    64'd1);
      chk("after_reset_valid", 64'(o_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/softmax_out_serializer.md
# softmax_out_serializer

Output stage placed directly downstream of the 64-lane softmax approximation pipeline. Captures each 1024-bit probability vector (64 × 16-bit lanes) with its length mode into a 2-entry buffer. Streams it out as 16 beats of 4 lanes over a valid/ready interface, marking row boundaries according to the length mode. Drives the pipeline's enable so that no vector is lost while the downstream consumer stalls.

## Interface
Parameters: none (lane count 64, lane width 16, beat width 64 are fixed).

- i_clk  in  1  clock; all state updates on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  probability vector present on i_prob_flat (softmax o_valid)
- i_prob_flat  in  1024  lane k at [k*16 +: 16]
- i_length_mode  in  4  mode aligned with i_prob_flat: 0 = 16-mode, 1 = 32-mode, 2 and above = 64-mode
- o_en  out  1  enable to the softmax pipeline; high when buffer can accept
- o_valid  out  1  beat available
- i_ready  in  1  consumer accepts beat
- o_data  out  64  lanes 4b..4b+3 of head vector, lane 4b+j at [j*16 +: 16]
- o_beat  out  4  beat index b, 0..15
- o_row  out  2  row index of current beat within the vector
- o_last  out  1  last beat of a row
- o_rows_done  out  16  count of completed rows, wraps

## Operation
- Reset, asserted asynchronously: every output and storage element clears.
  - Storage and counters become 0.
  - o_en = 1; o_valid, o_last = 0; o_data, o_beat, o_row, o_rows_done = 0.
- Buffer: 2 entries, each holding 1024-bit data plus 2-bit mode code (0 → 16, 1 → 32, 2 → 64).
  - Write pointer, read pointer and 2-bit count.
  - o_en = (count < 2). It depends only on count, never on i_ready.
- Push: when i_valid && o_en, write the entry at the write pointer.
  - i_valid while o_en = 0 is ignored. The upstream pipeline is frozen in that state and re-presents the same vector.
- Head output:
  - o_valid = (count != 0).
  - o_data = head[beat*64 +: 64] while valid; 0 when empty.
- Beat counter: advances on o_valid && i_ready.
  - After beat 15 is accepted: pop the head, beat returns to 0.
- Row and last:
  - 16-mode: o_row = beat[3:2]; o_last at beats 3, 7, 11, 15.
  - 32-mode: o_row = {1'b0, beat[3]}; o_last at beats 7, 15.
  - 64-mode: o_row = 0; o_last at beat 15 only.
  - o_row and o_last are 0 when o_valid = 0.
- o_rows_done increments by 1 on each accepted beat with o_last = 1. It wraps from 0xFFFF to 0.
- Simultaneous push and pop with count = 1: count stays 1, both pointers advance, and the new head is visible the next cycle.
- Push and pop with count = 2 cannot occur, because o_en = 0.
- o_valid holds until accepted. o_data, o_beat, o_row and o_last are stable while o_valid && !i_ready.

## Timing
- Capture-to-output latency: vector pushed at edge N into an empty buffer gives o_valid = 1 with beat 0 in the cycle after edge N.
- Throughput: one vector per 16 cycles with i_ready held high. Upstream is throttled through o_en only.
- o_en falls in the cycle after the second entry is written. It rises in the cycle after the final beat of the head is accepted.
- o_valid, o_data, o_row and o_last are combinational from registered state (count, pointers, beat, storage). There is no combinational path from i_ready or i_valid to any output.
- Reset mid-stream: outputs clear immediately (asynchronous). Partially sent and buffered vectors are discarded, and after release the block resumes empty with o_en = 1.

## Test plan
- Reset, single vector, 64-mode:
  - Stimulus: after reset, check o_en = 1, o_valid = 0, o_data = 0. Push lane k = k (16-bit), i_ready = 1.
  - Required: 16 beats follow. Beat b carries o_data = {4b+3, 4b+2, 4b+1, 4b}. o_last only at beat 15, o_row = 0, o_rows_done = 1.
- 16-mode and 32-mode framing:
  - Stimulus: a 16-mode vector, then a 32-mode vector.
  - Required: 16-mode gives o_last at beats 3/7/11/15 with o_row 0..3. 32-mode gives o_last at beats 7/15 with o_row 0/1. o_rows_done = 6.
- Backpressure fill:
  - Stimulus: hold i_ready = 0 and push 3 vectors on consecutive cycles.
  - Required: the first two are captured and o_en = 0 after the second. The third is ignored while o_en = 0, and it is captured once i_ready drains the head. The output sequence has no duplicated and no lost vectors.
- Random i_ready stall:
  - Stimulus: toggle i_ready pseudo-randomly.
  - Required: each beat is emitted exactly once. Outputs are stable while o_valid && !i_ready.
- Simultaneous push/pop:
  - Stimulus: with count = 1, push on the same cycle beat 15 is accepted.
  - Required: count stays 1 and the next cycle shows beat 0 of the new vector.
- Async reset mid-vector:
  - Stimulus: assert i_rst_n = 0 at beat 6 of a 2-entry buffer.
  - Required: outputs clear immediately (o_valid = 0, o_rows_done = 0). After release, o_en = 1 and no stale beat is emitted.
